// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver, LSB first.
// Start bit is qualified mid-bit; data and stop bits are sampled one bit period apart.
module uart_rx #(
  parameter int n   = 8,
  parameter int OVS = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         s_tick,
  input  logic         Rx_in,
  input  logic         rd_en,
  output logic [n-1:0] rx_data,
  output logic         rx_done,
  output logic         rx_ready,
  output logic         frame_err,
  output logic         overrun_err
);

  localparam int TW = $clog2(OVS);
  localparam int BW = (n > 1) ? $clog2(n) : 1;

  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(n - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic          sync1;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [n-1:0]  shreg;
  logic          done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= Rx_in;
      rx_s  <= sync1;
    end
  end

  assign done = (state == STOP) && s_tick
             && (tick_cnt == T_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_cnt == T_HALF) begin
              tick_cnt <= '0;
              // a high line at mid start bit is a glitch
              if (!rx_s) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt <= '0;
              shreg    <= n'({rx_s, shreg} >> 1);
              if (bit_cnt == B_LAST) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // completion flags all line up with the rx_done pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_data     <= '0;
      rx_done     <= 1'b0;
      rx_ready    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_done     <= done;
      frame_err   <= done & ~rx_s;
      overrun_err <= done & rx_ready & ~rd_en;
      if (done) begin
        rx_data  <= shreg;
        rx_ready <= 1'b1;
      end else if (rd_en) begin
        rx_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx.
// Expected words are queued as frames are driven and popped on rx_done.
module tb_uart_rx;

  localparam int N   = 8;
  localparam int OVS = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic         s_tick;
  logic         Rx_in;
  logic         rd_en;
  logic [N-1:0] rx_data;
  logic         rx_done;
  logic         rx_ready;
  logic         frame_err;
  logic         overrun_err;

  int checks = 0;
  int errors = 0;

  int  tick_div = 1;
  int  div_cnt  = 0;
  time t0       = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       ovr;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   edge_no;

  uart_rx #(.n(N), .OVS(OVS)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_tick     (s_tick),
    .Rx_in      (Rx_in),
    .rd_en      (rd_en),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_div <= 1) begin
      s_tick = 1'b1;
    end else begin
      s_tick  = (div_cnt == tick_div - 1);
      div_cnt = (div_cnt + 1) % tick_div;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      edge_no = int'(($time - t0) / 10);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: rx_done=1 data=%h, required no frame", rx_data);
      end else begin
        e = sb.pop_front();
        checks += 3;
        if (rx_data !== e.data) begin
          errors++;
          $display("FAIL rx_data: got %h, required %h", rx_data, e.data);
        end
        if (frame_err !== e.ferr) begin
          errors++;
          $display("FAIL frame_err: got %b, required %b", frame_err, e.ferr);
        end
        if (overrun_err !== e.ovr) begin
          errors++;
          $display("FAIL overrun_err: got %b, required %b", overrun_err, e.ovr);
        end
        if (rx_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_on_done: got %b, required 1", rx_ready);
        end
        if (e.lo > 0) begin
          checks++;
          if (edge_no < e.lo || edge_no > e.hi) begin
            errors++;
            $display("FAIL done_edge: got %0d, required %0d..%0d", edge_no, e.lo, e.hi);
          end
        end
      end
    end else if (frame_err === 1'b1 || overrun_err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL stray_err: frame_err=%b overrun_err=%b, required 0 without rx_done",
               frame_err, overrun_err);
    end
  end

  task automatic push(input logic [7:0] d, input logic ferr, input logic ovr,
                      input int lo, input int hi);
    exp_t x;
    x.data = d;
    x.ferr = ferr;
    x.ovr  = ovr;
    x.lo   = lo;
    x.hi   = hi;
    sb.push_back(x);
  endtask

  // rd_at: negedge index after frame start at which rd_en pulses (-1 = never)
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at);
    int bp;
    int k;
    logic [9:0] bits;
    bp   = OVS * tick_div;
    k    = 0;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    t0 = $time;
    for (int s = 0; s < 10; s++) begin
      Rx_in = bits[s];
      repeat (bp) begin
        @(negedge clk);
        k++;
        if (k == rd_at) rd_en = 1'b1;
        else if (k == rd_at + 1) rd_en = 1'b0;
      end
    end
    Rx_in = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_done: %0d frames pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic rd_clear(input string name);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_clear: rx_ready=%b, required 0", name, rx_ready);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({rx_data, rx_done, rx_ready, frame_err, overrun_err} !== '0) begin
      errors++;
      $display("FAIL %s: data=%h done=%b ready=%b ferr=%b ovr=%b, required all 0",
               name, rx_data, rx_done, rx_ready, frame_err, overrun_err);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("post_reset_idle");
  endtask

  task automatic test_basic;
    push(8'hA5, 1'b0, 1'b0, 155, 155);
    send_frame(8'hA5, 1'b1, -1);
    wait_drain("basic");
    repeat (4) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_hold: ready=%b data=%h, required 1 a5", rx_ready, rx_data);
    end
    rd_clear("basic");
  endtask

  task automatic test_glitch;
    @(negedge clk);
    Rx_in = 1'b0;
    repeat (4) @(negedge clk);
    Rx_in = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL glitch: ready=%b data=%h, required 0 a5", rx_ready, rx_data);
    end
  endtask

  task automatic test_frame_err;
    push(8'h3C, 1'b1, 1'b0, 155, 155);
    send_frame(8'h3C, 1'b0, -1);
    wait_drain("frame_err");
    repeat (40) @(negedge clk);
    rd_clear("frame_err");
  endtask

  task automatic test_overrun;
    push(8'h11, 1'b0, 1'b0, 155, 155);
    send_frame(8'h11, 1'b1, -1);
    push(8'h22, 1'b0, 1'b1, 155, 155);
    send_frame(8'h22, 1'b1, -1);
    wait_drain("overrun");
    repeat (4) @(negedge clk);
    rd_clear("overrun");
  endtask

  task automatic test_rd_same_cycle;
    push(8'h11, 1'b0, 1'b0, 155, 155);
    send_frame(8'h11, 1'b1, -1);
    push(8'h22, 1'b0, 1'b0, 155, 155);
    send_frame(8'h22, 1'b1, 154);
    wait_drain("rd_same");
    repeat (4) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || rx_data !== 8'h22) begin
      errors++;
      $display("FAIL rd_same_ready: ready=%b data=%h, required 1 22", rx_ready, rx_data);
    end
  endtask

  task automatic test_reset_mid;
    fork
      send_frame(8'hC3, 1'b1, -1);
      begin
        repeat (80) @(negedge clk);
        resetn = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check_zero("reset_mid");
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check_zero("reset_mid_after");
  endtask

  task automatic test_after_reset;
    push(8'h5A, 1'b0, 1'b0, 155, 155);
    send_frame(8'h5A, 1'b1, -1);
    wait_drain("after_reset");
    rd_clear("after_reset");
    rd_clear("rd_idle");
    checks++;
    if (rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL rd_idle_data: got %h, required 5a", rx_data);
    end
  endtask

  // 152 ticks after START entry at edge 3; first tick lands 1..4 clocks in
  task automatic test_slow_tick;
    tick_div = 4;
    repeat (8) @(negedge clk);
    push(8'hFF, 1'b0, 1'b0, 3 + 1 + 151 * 4, 3 + 4 + 151 * 4);
    send_frame(8'hFF, 1'b1, -1);
    wait_drain("slow_tick");
    tick_div = 1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    Rx_in  = 1'b1;
    rd_en  = 1'b0;
    s_tick = 1'b0;
    test_reset;
    test_basic;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_rd_same_cycle;
    test_reset_mid;
    test_after_reset;
    test_slow_tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
